// File: rtl/normalize32_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prj_definition (package)
// Description : Shared constants for the 32-bit sequential left-normalizer:
//               FSM state encodings, search step count, zero-operand count.
// Revision    : 1.0 - initial release
// ============================================================================
package prj_definition;

  // FSM encoding
  localparam int         c_STATE_W = 2;
  localparam logic [1:0] c_IDLE    = 2'b00;
  localparam logic [1:0] c_RUN     = 2'b01;
  localparam logic [1:0] c_FIN     = 2'b10;

  // Binary search: steps of 16, 8, 4, 2, 1 -> k runs 4..0
  localparam int         c_NUM_STEPS = 5;
  localparam int         c_STEP_W    = 3;
  localparam logic [2:0] c_FIRST_K   = 3'(c_NUM_STEPS - 1);

  // Count reported for an all-zero operand
  localparam logic [5:0] c_ZERO_CNT = 6'd32;

endpackage
`default_nettype wire

// File: rtl/normalize32_seq_norm_step.sv
`default_nettype none
// ============================================================================
// Module      : norm_step (+ MUX32_2x1)
// Description : One combinational stage of the normalizer binary search.
//               Shifts the word left by 2^k when its top 2^k bits are zero.
// Revision    : 1.0 - initial release
// ============================================================================

// 32-bit two-input multiplexer: i_sel=0 -> i_a0, i_sel=1 -> i_a1
module MUX32_2x1 (
  input  logic [31:0] i_a0,
  input  logic [31:0] i_a1,
  input  logic        i_sel,
  output logic [31:0] o_y
);

  assign o_y = i_sel ? i_a1 : i_a0;

endmodule

module norm_step
  import prj_definition::*;
(
  input  logic [31:0]         i_w,
  input  logic [c_STEP_W-1:0] i_k,
  output logic [31:0]         o_w,
  output logic                o_taken
);

  logic [5:0]  w_shamt;
  logic [31:0] w_mask;
  logic [31:0] w_shifted;

  // Step size 2^k and a mask selecting the top 2^k bits of the word
  assign w_shamt   = 6'd1 << i_k;
  assign w_mask    = ~(32'hFFFF_FFFF >> w_shamt);
  assign o_taken   = ((i_w & w_mask) == 32'd0);
  assign w_shifted = i_w << w_shamt;

  MUX32_2x1 u_mux (
    .i_a0  (i_w),
    .i_a1  (w_shifted),
    .i_sel (o_taken),
    .o_y   (o_w)
  );

endmodule
`default_nettype wire

// File: rtl/normalize32_seq.sv
`default_nettype none
// ============================================================================
// Module      : normalize32_seq
// Description : Sequential 32-bit left-normalizer. Finds the leading-zero
//               count with a 5-step binary search (16/8/4/2/1), one stage
//               per clock, and returns the normalized word, the count and a
//               zero flag behind a START/BUSY/DONE handshake.
//               Optional macro NORM_EARLY_DONE_EN: finish as soon as the
//               working word is already normalized (or the operand is zero).
// Revision    : 1.0 - initial release
// ============================================================================
module normalize32_seq
  import prj_definition::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] D,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Y,
  output logic [CNT_W-1:0] CNT,
  output logic             ZERO
);

  logic [c_STATE_W-1:0] r_state;
  logic [c_STATE_W-1:0] w_state_next;
  logic [WIDTH-1:0]     r_w;
  logic [CNT_W-1:0]     r_cnt;
  logic [c_STEP_W-1:0]  r_k;
  logic                 r_zero_op;
  logic [WIDTH-1:0]     r_y;
  logic [CNT_W-1:0]     r_cnt_out;
  logic                 r_zero_out;

  logic [WIDTH-1:0]     w_w_next;
  logic                 w_taken;
  logic [CNT_W-1:0]     w_cnt_next;
  logic                 w_accept;
  logic                 w_run_done;

  norm_step u_step (
    .i_w     (r_w),
    .i_k     (r_k),
    .o_w     (w_w_next),
    .o_taken (w_taken)
  );

  assign w_cnt_next = w_taken ? (r_cnt + (CNT_W'(1) << r_k)) : r_cnt;

  // A new operation may start from IDLE or from the DONE cycle
  assign w_accept = START && ((r_state == c_IDLE) || (r_state == c_FIN));

`ifdef NORM_EARLY_DONE_EN
  // Once bit 31 is set the remaining steps cannot shift; a zero operand
  // has a forced result, so neither needs the rest of the search.
  assign w_run_done = (r_k == '0) || r_w[WIDTH-1] || r_zero_op;
`else
  assign w_run_done = (r_k == '0);
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (w_accept) w_state_next = c_RUN;
      c_RUN:   if (w_run_done) w_state_next = c_FIN;
      c_FIN:   w_state_next = w_accept ? c_RUN : c_IDLE;
      default: w_state_next = c_IDLE;
    endcase
  end

  // Working word, count, step index and result registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_w        <= '0;
      r_cnt      <= '0;
      r_k        <= c_FIRST_K;
      r_zero_op  <= 1'b0;
      r_y        <= '0;
      r_cnt_out  <= '0;
      r_zero_out <= 1'b0;
    end else if (w_accept) begin
      r_w       <= D;
      r_cnt     <= '0;
      r_k       <= c_FIRST_K;
      r_zero_op <= (D == '0);
    end else if (r_state == c_RUN) begin
      r_w   <= w_w_next;
      r_cnt <= w_cnt_next;
      r_k   <= r_k - 3'd1;
      // Results only change on the edge entering FIN; a zero operand
      // reports 32 instead of the 31 the search would produce.
      if (w_run_done) begin
        r_zero_out <= r_zero_op;
        r_y        <= r_zero_op ? '0 : w_w_next;
        r_cnt_out  <= r_zero_op ? CNT_W'(c_ZERO_CNT) : w_cnt_next;
      end
    end
  end

  // Handshake and result outputs
  always_comb begin
    BUSY = (r_state == c_RUN);
    DONE = (r_state == c_FIN);
    Y    = r_y;
    CNT  = r_cnt_out;
    ZERO = r_zero_out;
  end

endmodule
`default_nettype wire

// File: tb/tb_normalize32_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_normalize32_seq
// Description : Scoreboard testbench for normalize32_seq. The driver pushes
//               the expected result and DONE cycle of each accepted operand;
//               a monitor pops and compares on every DONE pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_normalize32_seq;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [31:0] D;
  logic        BUSY;
  logic        DONE;
  logic [31:0] Y;
  logic [5:0]  CNT;
  logic        ZERO;

  typedef struct {
    logic [31:0] y;
    logic [5:0]  cnt;
    logic        zero;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_total  = 0;
  int   n_pass   = 0;
  int   n_done   = 0;
  int   n_issued = 0;

  normalize32_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .D     (D),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .Y     (Y),
    .CNT   (CNT),
    .ZERO  (ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference: leading zeros by locating the highest set bit
  function automatic exp_t model(input logic [31:0] d, input int ecyc);
    exp_t e;
    int   lz  = 32;
    int   lat = 5;
    for (int b = 0; b < 32; b++) if (d[b]) lz = 31 - b;
    e.zero = (d == 32'd0);
    e.cnt  = 6'(lz);
    e.y    = e.zero ? 32'd0 : (d << lz);
`ifdef NORM_EARLY_DONE_EN
    // The search consumes the count's bits MSB first, so the word is
    // normalized once all set bits of the count have been consumed.
    if (e.zero || lz == 0) lat = 1;
    else begin
      int tz = 0;
      while (((lz >> tz) & 1) == 0) tz++;
      lat = (6 - tz > 5) ? 5 : 6 - tz;
    end
`endif
    e.done_cyc = ecyc + lat;
    return e;
  endfunction

  // Wait for an accepting cycle, present the operand for one edge
  task automatic issue(input logic [31:0] d, input bit push);
    int guard = 0;
    @(negedge CLK);
    while (BUSY && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 100) begin
      n_total++;
      $display("FAIL issue_timeout: BUSY stuck at %0b, expected 0", BUSY);
    end
    START = 1'b1;
    D     = d;
    @(posedge CLK);
    #1;
    START = 1'b0;
    if (push) begin
      sb.push_back(model(d, cyc));
      n_issued++;
    end
  endtask

  // Monitor: compare every DONE pulse against the oldest expectation
  always @(negedge CLK) begin
    if (!RST && DONE) begin
      n_done++;
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: DONE=1 with Y=%0h CNT=%0d, expected no pulse", Y, CNT);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("y",        64'(Y),    64'(e.y));
        chk("cnt",      64'(CNT),  64'(e.cnt));
        chk("zero",     64'(ZERO), 64'(e.zero));
        chk("done_cyc", 64'(cyc),  64'(e.done_cyc));
      end
    end
  end

  initial begin
    RST   = 1'b1;
    START = 1'b0;
    D     = 32'd0;
    repeat (3) @(negedge CLK);
    START = 1'b1;
    D     = 32'hFFFF_FFFF;
    @(negedge CLK);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);
    chk("rst_y",    64'(Y),    64'd0);
    chk("rst_cnt",  64'(CNT),  64'd0);
    chk("rst_zero", 64'(ZERO), 64'd0);
    START = 1'b0;
    RST   = 1'b0;

    // Single 1 in the LSB: BUSY for five cycles, then FIN
    issue(32'h0000_0001, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("busy_run", 64'(BUSY), 64'd1);
    end
    @(negedge CLK);
    chk("busy_fin", 64'(BUSY), 64'd0);

    issue(32'h8000_0000, 1'b1);
    issue(32'h0000_0000, 1'b1);

    // Second START during RUN must be ignored
    issue(32'h0001_2345, 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    START = 1'b1;
    D     = 32'hFFFF_FFFF;
    @(posedge CLK);
    #1;
    START = 1'b0;

    // Reset in the middle of RUN aborts without a DONE pulse
    issue(32'h0000_0F00, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_busy", 64'(BUSY), 64'd0);
    chk("abort_done", 64'(DONE), 64'd0);
    chk("abort_y",    64'(Y),    64'd0);
    chk("abort_cnt",  64'(CNT),  64'd0);
    chk("abort_zero", 64'(ZERO), 64'd0);
    RST = 1'b0;
    repeat (10) @(negedge CLK);

    // Back-to-back: second operand accepted in the FIN cycle
    issue(32'h0000_0100, 1'b1);
    issue(32'h4000_0000, 1'b1);

    // Randomized operands with mixed magnitudes, gaps and stray STARTs
    for (int n = 0; n < 40; n++) begin
      logic [31:0] d;
      d = $urandom() >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) d = 32'd0;
      issue(d, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge CLK);
        START = 1'b1;
        D     = $urandom();
        @(posedge CLK);
        #1;
        START = 1'b0;
      end
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    begin
      int guard = 0;
      while (sb.size() != 0 && guard < 100) begin
        @(negedge CLK);
        guard++;
      end
    end
    repeat (3) @(negedge CLK);
    chk("sb_empty",   64'(sb.size()), 64'd0);
    chk("done_count", 64'(n_done),    64'(n_issued));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
